// File: rtl/led_pkg.sv
// Shared display-mode encodings for the switch-to-LED controller family.
package led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_PASS   = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_t;

    // Mode sequence stepped by each button press; CHASE wraps back to PASS.
    function automatic mode_t next_mode(input mode_t cur);
        case (cur)
            MODE_PASS:   next_mode = MODE_INVERT;
            MODE_INVERT: next_mode = MODE_BLINK;
            MODE_BLINK:  next_mode = MODE_CHASE;
            default:     next_mode = MODE_PASS;
        endcase
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, hold-time debounce and a
// one-cycle press pulse on each accepted rising level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4194304
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: non-blocking assignments let sync1 -> sync2 form a real two-stage
    // shift; blocking here would collapse the synchroniser into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            press    <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable & ~stable_d;

            // Any return to the accepted level restarts the hold window.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_mode_controller.sv
// Switch-to-LED controller: a debounced button steps through four display
// modes (pass, invert, blink, chase); LED drive and mode are registered.
module led_mode_controller
    import led_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 4194304,
    parameter int BLINK_CYCLES    = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  switches,
    input  logic              up,
    output logic [WIDTH-1:0]  leds,
    output logic [MODE_W-1:0] mode
);

    localparam int                TICK_W      = $clog2(BLINK_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(BLINK_CYCLES - 1);
    localparam logic [WIDTH-1:0]  CHASE_START = WIDTH'(1);

    logic              press;
    logic              unused_btn_level;
    mode_t             mode_q;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              blink_phase;
    logic [WIDTH-1:0]  chase_pos;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_up_btn (
        .clk   (clk),
        .rst   (rst),
        .raw   (up),
        .stable(unused_btn_level),
        .press (press)
    );

    assign tick = (tick_cnt == TICK_LAST);
    assign mode = mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_PASS;
            leds        <= '0;
            tick_cnt    <= '0;
            blink_phase <= 1'b1;
            chase_pos   <= CHASE_START;
        end else begin
            // A mode change restarts the display timebase, overriding a coincident tick.
            if (press) begin
                mode_q      <= next_mode(mode_q);
                tick_cnt    <= '0;
                blink_phase <= 1'b1;
                chase_pos   <= CHASE_START;
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick) begin
                    blink_phase <= ~blink_phase;
                    chase_pos   <= (chase_pos << 1) | (chase_pos >> (WIDTH - 1));
                end
            end

            case (mode_q)
                MODE_PASS:   leds <= switches;
                MODE_INVERT: leds <= ~switches;
                MODE_BLINK:  leds <= blink_phase ? switches : '0;
                MODE_CHASE:  leds <= chase_pos & switches;
                default:     leds <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_led_mode_controller.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized button/switch/reset stimulus compared every cycle to a timing model.
module tb_led_mode_controller;

    localparam int WIDTH = 3;
    localparam int DEB   = 4;
    localparam int BLINK = 4;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             up       = 1'b0;
    logic [WIDTH-1:0] switches = '0;
    logic [WIDTH-1:0] leds;
    logic [1:0]       mode;

    int vectors     = 0;
    int miscompares = 0;

    led_mode_controller #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_CYCLES   (BLINK)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .switches(switches),
        .up      (up),
        .leds    (leds),
        .mode    (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: button level seen two cycles late, accepted after DEB consecutive
    // disagreeing samples; a rising acceptance moves the mode two cycles later.
    // Display state is derived from cycles elapsed since the last mode change.
    bit               m_valid = 1'b0;
    int               m_mode;
    int               m_age;
    int               m_stable;
    int               m_run;
    bit               adv1;
    bit               adv2;
    int               sync_q[$];
    logic [WIDTH-1:0] m_leds;

    always @(posedge clk) begin : model
        int ticks;
        int s2;
        bit do_adv;
        if (rst) begin
            m_mode   = 0;
            m_leds   = '0;
            m_age    = 0;
            m_stable = 0;
            m_run    = 0;
            adv1     = 1'b0;
            adv2     = 1'b0;
            sync_q   = '{0, 0};
            m_valid  = 1'b1;
        end else if (m_valid) begin
            ticks = m_age / BLINK;
            case (m_mode)
                0:       m_leds = switches;
                1:       m_leds = ~switches;
                2:       m_leds = (ticks % 2 == 0) ? switches : '0;
                3:       m_leds = switches & WIDTH'(1 << (ticks % WIDTH));
                default: m_leds = '0;
            endcase
            m_age++;

            do_adv = adv2;
            adv2   = adv1;
            adv1   = 1'b0;

            s2 = sync_q.pop_front();
            sync_q.push_back(int'(up));
            if (s2 != m_stable) m_run++;
            else m_run = 0;
            if (m_run == DEB) begin
                m_stable = s2;
                m_run    = 0;
                adv1     = (s2 == 1);
            end

            if (do_adv) begin
                m_mode = (m_mode + 1) % 4;
                m_age  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_leds", int'(leds), int'(m_leds));
            check("model_mode", int'(mode), m_mode);
        end
    end

    // Raise the button and expect exactly one advance on the 8th edge.
    task automatic press_hold(input int exp_mode);
        up = 1'b1;
        repeat (7) @(negedge clk);
        check("pre_adv_mode", int'(mode), (exp_mode + 3) % 4);
        @(negedge clk);
        check("adv_mode", int'(mode), exp_mode);
    endtask

    task automatic release_btn();
        up = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        // Reset behaviour
        rst      = 1'b1;
        up       = 1'b0;
        switches = 3'b101;
        repeat (2) @(negedge clk);
        check("rst_leds", int'(leds), 0);
        check("rst_mode", int'(mode), 0);
        rst = 1'b0;
        @(negedge clk);
        check("pass_leds", int'(leds), 3'b101);

        // Clean press, then release
        press_hold(1);
        @(negedge clk);
        check("invert_leds", int'(leds), 3'b010);
        @(negedge clk);
        release_btn();
        check("release_no_adv", int'(mode), 1);

        // Bounce then hold -> blink
        switches = 3'b111;
        for (int i = 0; i < 4; i++) begin
            up = (i % 2 == 0);
            @(negedge clk);
        end
        check("bounce_no_adv", int'(mode), 1);
        press_hold(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("blink_on", int'(leds), 3'b111);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("blink_off", int'(leds), 3'b000);
        end
        @(negedge clk);
        check("blink_on2", int'(leds), 3'b111);
        release_btn();

        // Short glitch must not advance
        up = 1'b1;
        repeat (3) @(negedge clk);
        up = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_no_adv", int'(mode), 2);

        // Chase sequence, masking, wrap to pass
        press_hold(3);
        @(negedge clk);
        check("chase0", int'(leds), 3'b001);
        repeat (4) @(negedge clk);
        check("chase1", int'(leds), 3'b010);
        repeat (4) @(negedge clk);
        check("chase2", int'(leds), 3'b100);
        repeat (4) @(negedge clk);
        check("chase_wrap", int'(leds), 3'b001);
        switches = 3'b010;
        @(negedge clk);
        check("chase_masked", int'(leds), 3'b000);
        repeat (3) @(negedge clk);
        check("chase_slot", int'(leds), 3'b010);
        release_btn();
        press_hold(0);
        @(negedge clk);
        check("wrap_pass", int'(leds), 3'b010);
        release_btn();

        // Reset mid-operation with the button half-debounced
        press_hold(1);
        release_btn();
        press_hold(2);
        release_btn();
        press_hold(3);
        release_btn();
        up = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_mode", int'(mode), 0);
        check("midrst_leds", int'(leds), 0);
        rst = 1'b0;
        press_hold(1);
        release_btn();

        // Randomized stimulus, checked by the model every cycle
        for (int n = 0; n < 300; n++) begin
            up       = 1'($urandom_range(1, 0));
            switches = WIDTH'($urandom);
            rst      = ($urandom_range(99, 0) == 0);
            repeat ($urandom_range(10, 1)) @(negedge clk);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
